tick_timer_ctrl: RTL and testbench

- Programmable controller that sequences the board's tick/divided-clock generation: configures the period, starts and stops counting, and runs one-shot or periodic modes.
- Produces a single-cycle `tick` enable and a toggling `div_out` level (50% duty over 2×(period+1) cycles).
- Sits between control logic (FSMs, button handlers) and any downstream block needing slow timing, such as LED blinkers or display refresh.

---
 rtl/tick_timer_pkg.sv | 22 ++
 rtl/tick_counter.sv | 55 +++++
 rtl/tick_timer_ctrl.sv | 139 +++++++++++++
 tb/tb_tick_timer_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
// Shared state encoding, mode codes and default period for the tick timer controller.
`timescale 1ns/1ps
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STOP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;

    localparam int unsigned DEF_PERIOD = 32'd40000000;

    // Only one-shot and periodic may launch a run; stop and the reserved code never do.
    function automatic logic isRunMode(input logic [1:0] mode);
        return (mode == MODE_ONESHOT) || (mode == MODE_PERIODIC);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Counter/compare datapath: counts up to the period, emits an expiry, a registered
// one-cycle tick and a divided level that toggles on every expiry.
`timescale 1ns/1ps
module tick_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock_n,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             expire_o,
    output logic             tick_o,
    output logic             div_o
);
    import tick_timer_pkg::*;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;
    logic             div_q;
    logic             div_d;
    logic             atTerminal;

    // A clear (start, restart or stop) wins over an expiry landing on the same edge.
    always_comb begin
        atTerminal = (count_q == period_i);
        expire_o   = enable_i && !clear_i && atTerminal;
        count_d    = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
        tick_d = expire_o;
        div_d  = div_q ^ expire_o;
    end

    always_ff @(negedge clock_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
        end
    end

    assign tick_o = tick_q;
    assign div_o  = div_q;

endmodule

// File: rtl/tick_timer_ctrl.sv
// Tick timer controller: config handshake and IDLE/RUN/DONE sequencing around tick_counter.
// Optional pause input enabled by defining TICK_TIMER_CTRL_PAUSE_EN.
`timescale 1ns/1ps
module tick_timer_ctrl #(
    parameter int          CNT_W      = 32,
    parameter int          EXP_W      = 16,
    parameter int unsigned DEF_PERIOD = tick_timer_pkg::DEF_PERIOD
) (
    input  logic             clock_n,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [1:0]       cfg_mode,
    input  logic             start,
    input  logic             stop,
`ifdef TICK_TIMER_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tick,
    output logic             div_out,
    output logic             busy,
    output logic [EXP_W-1:0] expire_cnt
);
    import tick_timer_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [EXP_W-1:0] expireCnt_q;
    logic [EXP_W-1:0] expireCnt_d;

    logic             cfgAccept;
    logic [1:0]       effMode;
    logic             startRun;
    logic             restartRun;
    logic             stopRun;
    logic             counterClear;
    logic             runEnable;
    logic             expire;

`ifdef TICK_TIMER_CTRL_PAUSE_EN
    assign runEnable = (state_q == RUN) && !pause;
`else
    assign runEnable = (state_q == RUN);
`endif

    // A config arriving with start in IDLE is the one the new run uses.
    always_comb begin
        cfgAccept    = (state_q == IDLE) && cfg_valid;
        effMode      = cfgAccept ? cfg_mode : mode_q;
        startRun     = (state_q == IDLE) && start && isRunMode(effMode);
        stopRun      = (state_q == RUN) && stop;
        restartRun   = (state_q == RUN) && start && !stop;
        counterClear = startRun || restartRun || stopRun;
    end

    tick_counter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .clock_n  (clock_n),
        .reset_n  (reset_n),
        .clear_i  (counterClear),
        .enable_i (runEnable),
        .period_i (period_q),
        .expire_o (expire),
        .tick_o   (tick),
        .div_o    (div_out)
    );

    always_ff @(negedge clock_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startRun) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stopRun) begin
                    state_d = IDLE;
                end else if (restartRun) begin
                    state_d = RUN;
                end else if (expire && (mode_q == MODE_ONESHOT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        cfg_ready = (state_q == IDLE);
    end

    // Expiry count restarts with every run and sticks at all-ones.
    always_comb begin
        period_d    = cfgAccept ? cfg_period : period_q;
        mode_d      = cfgAccept ? cfg_mode : mode_q;
        expireCnt_d = expireCnt_q;
        if (startRun || restartRun) begin
            expireCnt_d = '0;
        end else if (expire && !(&expireCnt_q)) begin
            expireCnt_d = expireCnt_q + EXP_W'(1);
        end
    end

    always_ff @(negedge clock_n) begin
        if (!reset_n) begin
            period_q    <= CNT_W'(DEF_PERIOD);
            mode_q      <= MODE_STOP;
            expireCnt_q <= '0;
        end else begin
            period_q    <= period_d;
            mode_q      <= mode_d;
            expireCnt_q <= expireCnt_d;
        end
    end

    assign expire_cnt = expireCnt_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Self-checking bench for tick_timer_ctrl: elapsed-time model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_tick_timer_ctrl;

    logic        clock_n = 1'b1;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0;
    logic [1:0]  cfg_mode = 2'b00;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef TICK_TIMER_CTRL_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        tick;
    logic        div_out;
    logic        busy;
    logic [15:0] expire_cnt;

    int checks = 0;
    int errors = 0;

    tick_timer_ctrl dut (
        .clock_n    (clock_n),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
`ifdef TICK_TIMER_CTRL_PAUSE_EN
        .pause      (pause),
`endif
        .tick       (tick),
        .div_out    (div_out),
        .busy       (busy),
        .expire_cnt (expire_cnt)
    );

    always #5 clock_n = ~clock_n;

    // Model: a run is described by cycles elapsed since start; expiry when elapsed is a multiple of period+1.
    bit     mRun = 0;
    bit     mDone = 0;
    bit     mTick = 0;
    bit     mDiv = 0;
    int     mCnt = 0;
    longint mPeriod = 40000000;
    int     mMode = 0;
    longint mElapsed = 0;

    always @(negedge clock_n) begin
        bit fire;
        fire = 0;
        if (!reset_n) begin
            mRun = 0; mDone = 0; mDiv = 0; mCnt = 0;
            mPeriod = 40000000; mMode = 0; mElapsed = 0;
        end else if (mDone) begin
            mDone = 0;
        end else if (!mRun) begin
            if (cfg_valid) begin
                mPeriod = cfg_period;
                mMode = cfg_mode;
            end
            if (start && (mMode == 1 || mMode == 2)) begin
                mRun = 1; mElapsed = 0; mCnt = 0;
            end
        end else if (stop) begin
            mRun = 0;
        end else if (start) begin
            mElapsed = 0; mCnt = 0;
        end else begin
            mElapsed++;
            if (mElapsed % (mPeriod + 1) == 0) begin
                fire = 1;
                if (mMode == 1) begin
                    mRun = 0; mDone = 1;
                end
            end
        end
        mTick = fire;
        if (fire) begin
            mDiv = !mDiv;
            if (mCnt < 65535) mCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic compareModel();
        checkOutput("model_tick", 64'(tick), 64'(mTick));
        checkOutput("model_div_out", 64'(div_out), 64'(mDiv));
        checkOutput("model_busy", 64'(busy), 64'(mRun));
        checkOutput("model_cfg_ready", 64'(cfg_ready), 64'(!mRun && !mDone));
        checkOutput("model_expire_cnt", 64'(expire_cnt), 64'(mCnt));
    endtask

    // Each call lets one falling edge consume the current inputs, then checks against the model.
    task automatic applyStimulus();
        @(posedge clock_n);
        compareModel();
        #1;
    endtask

    task automatic launch(input logic [31:0] period, input logic [1:0] mode);
        cfg_valid = 1'b1; cfg_period = period; cfg_mode = mode; start = 1'b1;
        applyStimulus();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        applyStimulus();
        applyStimulus();
        checkOutput("reset_tick", 64'(tick), 64'd0);
        checkOutput("reset_div_out", 64'(div_out), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_expire_cnt", 64'(expire_cnt), 64'd0);
        checkOutput("reset_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("reset_period", 64'(dut.period_q), 64'd40000000);
        reset_n = 1'b1;

        launch(32'd3, 2'b10);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
            checkOutput($sformatf("periodic_tick_%0d", i), 64'(tick), 64'((i % 4) == 0));
            if (i == 2) begin
                checkOutput("periodic_busy", 64'(busy), 64'd1);
                checkOutput("periodic_cfg_ready", 64'(cfg_ready), 64'd0);
            end
            if (i == 4) checkOutput("periodic_div_4", 64'(div_out), 64'd1);
            if (i == 8) checkOutput("periodic_div_8", 64'(div_out), 64'd0);
        end
        checkOutput("periodic_div_12", 64'(div_out), 64'd1);
        checkOutput("periodic_expire_cnt", 64'(expire_cnt), 64'd3);

        cfg_valid = 1'b1; cfg_period = 32'd9; cfg_mode = 2'b10; stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkOutput("cfg_in_run_ignored", 64'(dut.period_q), 64'd3);
        checkOutput("stop_busy", 64'(busy), 64'd0);
        checkOutput("stop_div_held", 64'(div_out), 64'd1);
        applyStimulus();
        cfg_valid = 1'b0;
        checkOutput("cfg_after_stop", 64'(dut.period_q), 64'd9);

        launch(32'd5, 2'b01);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("oneshot_tick_%0d", i), 64'(tick), 64'(i == 6));
            checkOutput($sformatf("oneshot_busy_%0d", i), 64'(busy), 64'(i < 6));
            checkOutput($sformatf("oneshot_ready_%0d", i), 64'(cfg_ready), 64'(i >= 7));
        end
        checkOutput("oneshot_expire_cnt", 64'(expire_cnt), 64'd1);
        checkOutput("oneshot_div", 64'(div_out), 64'd0);

        launch(32'd2, 2'b10);
        applyStimulus();
        applyStimulus();
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkOutput("collision_tick", 64'(tick), 64'd0);
        checkOutput("collision_div", 64'(div_out), 64'd0);
        checkOutput("collision_busy", 64'(busy), 64'd0);
        checkOutput("collision_expire_cnt", 64'(expire_cnt), 64'd0);

        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("pre_restart_tick", 64'(tick), 64'd1);
        checkOutput("pre_restart_cnt", 64'(expire_cnt), 64'd1);
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("restart_cnt", 64'(expire_cnt), 64'd0);
        checkOutput("restart_tick", 64'(tick), 64'd0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("post_restart_tick", 64'(tick), 64'd1);
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;

        cfg_valid = 1'b1; cfg_period = 32'd0; cfg_mode = 2'b11; start = 1'b1;
        applyStimulus();
        cfg_valid = 1'b0; start = 1'b0;
        checkOutput("reserved_mode_ignored", 64'(busy), 64'd0);

        launch(32'd0, 2'b10);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("period0_tick_%0d", i), 64'(tick), 64'd1);
        end
        checkOutput("period0_expire_cnt", 64'(expire_cnt), 64'd5);

        reset_n = 1'b0;
        applyStimulus();
        checkOutput("midrun_reset_tick", 64'(tick), 64'd0);
        checkOutput("midrun_reset_div", 64'(div_out), 64'd0);
        checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
        checkOutput("midrun_reset_cnt", 64'(expire_cnt), 64'd0);
        checkOutput("midrun_reset_ready", 64'(cfg_ready), 64'd1);
        checkOutput("midrun_reset_period", 64'(dut.period_q), 64'd40000000);
        reset_n = 1'b1;
        applyStimulus();
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
